// File: rtl/fifo_lsram_ctrl.sv
// fifo_lsram_ctrl: first-word-fall-through FIFO over a 512x32 LSRAM with a 2-cycle registered read
//   CLK, SRST          : clock, synchronous active-high reset
//   WR_DATA/VALID/READY: producer handshake
//   RD_DATA/VALID/READY: consumer handshake, head word shown without a request
//   COUNT, FULL, EMPTY, AFULL, AEMPTY: total occupancy and status flags
//   RAM_*              : LSRAM write port, read port and registered read data
module fifo_lsram_ctrl #(
  parameter int AFULL_THRESH = 500,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic        CLK,
  input  logic        SRST,
  input  logic [31:0] WR_DATA,
  input  logic        WR_VALID,
  output logic        WR_READY,
  output logic [31:0] RD_DATA,
  output logic        RD_VALID,
  input  logic        RD_READY,
  output logic [9:0]  COUNT,
  output logic        FULL,
  output logic        EMPTY,
  output logic        AFULL,
  output logic        AEMPTY,
  output logic [31:0] RAM_WD,
  output logic [8:0]  RAM_WADDR,
  output logic        RAM_WEN,
  output logic [8:0]  RAM_RADDR,
  output logic        RAM_REN,
  output logic        RAM_RD_EN,
  output logic        RAM_RD_SRST_N,
  input  logic [31:0] RAM_RD
);
  logic [9:0] wptr, rptr, occ, cnt_n;
  logic [1:0] infl, bcnt, wi, pipe;
  logic [2:0] used;
  logic [2:0][31:0] ob, ob_n;
  logic wr_fire, rd_fire, cap;
  // 10-bit pointers make the difference wrap-safe and let it reach 512
  assign occ = wptr - rptr;
  assign FULL = occ == 10'd512;
  assign WR_READY = !FULL;
  assign wr_fire = WR_VALID && WR_READY && !SRST;
  assign rd_fire = RD_VALID && RD_READY;
  assign cap = pipe[1];
  // a same-cycle pop frees its slot, so it counts toward the read credit
  assign used = {1'b0, bcnt} + {1'b0, infl} - {2'b0, rd_fire};
  assign RAM_REN = !SRST && occ != 10'd0 && used < 3'd3;
  assign RAM_WEN = wr_fire;
  assign RAM_WD = WR_DATA;
  assign RAM_WADDR = wptr[8:0];
  assign RAM_RADDR = rptr[8:0];
  assign RAM_RD_EN = 1'b1;
  assign RAM_RD_SRST_N = !SRST;
  assign RD_VALID = bcnt != 2'd0;
  assign RD_DATA = ob[0];
  assign cnt_n = COUNT + {9'd0, wr_fire} - {9'd0, rd_fire};
  // captured word lands just behind the head after any same-cycle pop shift
  assign wi = bcnt - {1'b0, rd_fire};
  always_comb begin
    ob_n = rd_fire ? {32'd0, ob[2:1]} : ob;
    if (cap) ob_n[wi] = RAM_RD;
  end
  always_ff @(posedge CLK)
    if (SRST) begin
      wptr <= '0;
      rptr <= '0;
      pipe <= '0;
      infl <= '0;
      bcnt <= '0;
      ob <= '0;
      COUNT <= '0;
      EMPTY <= 1'b1;
      AEMPTY <= 1'b1;
      AFULL <= 1'b0;
    end else begin
      wptr <= wptr + {9'd0, wr_fire};
      rptr <= rptr + {9'd0, RAM_REN};
      pipe <= {pipe[0], RAM_REN};
      infl <= infl + {1'b0, RAM_REN} - {1'b0, cap};
      bcnt <= bcnt + {1'b0, cap} - {1'b0, rd_fire};
      ob <= ob_n;
      COUNT <= cnt_n;
      EMPTY <= cnt_n == 10'd0;
      AFULL <= cnt_n >= 10'(AFULL_THRESH);
      AEMPTY <= cnt_n <= 10'(AEMPTY_THRESH);
    end
endmodule

// File: tb/tb_fifo_lsram_ctrl.sv
// tb_fifo_lsram_ctrl: directed and randomized checks of fifo_lsram_ctrl against an LSRAM model and a queue
module tb_fifo_lsram_ctrl;
  logic        CLK, SRST;
  logic [31:0] WR_DATA, RD_DATA, RAM_WD, RAM_RD;
  logic        WR_VALID, WR_READY, RD_VALID, RD_READY;
  logic [9:0]  COUNT;
  logic        FULL, EMPTY, AFULL, AEMPTY;
  logic [8:0]  RAM_WADDR, RAM_RADDR;
  logic        RAM_WEN, RAM_REN, RAM_RD_EN, RAM_RD_SRST_N;
  logic [31:0] mem [512];
  logic [31:0] s1;
  logic [31:0] q [$];
  int n_cmp = 0;
  int n_bad = 0;
  fifo_lsram_ctrl dut (
    .CLK(CLK), .SRST(SRST), .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY), .COUNT(COUNT),
    .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .AEMPTY(AEMPTY),
    .RAM_WD(RAM_WD), .RAM_WADDR(RAM_WADDR), .RAM_WEN(RAM_WEN), .RAM_RADDR(RAM_RADDR),
    .RAM_REN(RAM_REN), .RAM_RD_EN(RAM_RD_EN), .RAM_RD_SRST_N(RAM_RD_SRST_N), .RAM_RD(RAM_RD)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  // LSRAM with registered read: data valid two cycles after REN
  always @(posedge CLK) begin
    if (RAM_WEN) mem[RAM_WADDR] <= RAM_WD;
    if (RAM_REN) s1 <= mem[RAM_RADDR];
    RAM_RD <= s1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge CLK);
    SRST = 1'b1;
    WR_VALID = 1'b0;
    RD_READY = 1'b0;
    @(negedge CLK);
    SRST = 1'b0;
    q.delete();
  endtask
  task automatic traffic(input int n, input int wp, input int rp, input int steady);
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      WR_VALID = $urandom_range(99) < wp;
      WR_DATA = $urandom;
      RD_READY = $urandom_range(99) < rp;
      #1;
      chk("tr_count", {22'd0, COUNT}, q.size());
      chk("tr_empty", EMPTY, q.size() == 0);
      chk("tr_afull", AFULL, q.size() >= 500);
      chk("tr_aempty", AEMPTY, q.size() <= 4);
      if (steady >= 0 && c >= 4) chk("steady_count", {22'd0, COUNT}, steady);
      if (RD_VALID && RD_READY) begin
        if (q.size() == 0) chk("tr_dup", RD_VALID, 1'b0);
        else chk("tr_data", RD_DATA, q.pop_front());
      end
      if (WR_VALID && WR_READY) q.push_back(WR_DATA);
    end
  endtask
  initial begin
    int n;
    SRST = 1'b1;
    WR_VALID = 1'b0;
    RD_READY = 1'b0;
    WR_DATA = '0;
    @(negedge CLK);
    WR_VALID = 1'b1;
    @(negedge CLK);
    #1;
    chk("rst_empty", EMPTY, 1'b1);
    chk("rst_aempty", AEMPTY, 1'b1);
    chk("rst_full", FULL, 1'b0);
    chk("rst_afull", AFULL, 1'b0);
    chk("rst_rd_valid", RD_VALID, 1'b0);
    chk("rst_rd_data", RD_DATA, 32'd0);
    chk("rst_wr_ready", WR_READY, 1'b1);
    chk("rst_count", {22'd0, COUNT}, 0);
    chk("rst_wen", RAM_WEN, 1'b0);
    chk("rst_ren", RAM_REN, 1'b0);
    chk("rst_srst_n", RAM_RD_SRST_N, 1'b0);
    chk("rd_en", RAM_RD_EN, 1'b1);
    SRST = 1'b0;
    WR_VALID = 1'b0;
    // single word latency into an empty FIFO
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      WR_VALID = c == 0;
      WR_DATA = 32'hDEADBEEF;
      RD_READY = 1'b1;
      #1;
      case (c)
        0: begin
          chk("c0_wen", RAM_WEN, 1'b1);
          chk("c0_waddr", {23'd0, RAM_WADDR}, 0);
          chk("c0_wd", RAM_WD, 32'hDEADBEEF);
          chk("c0_ren", RAM_REN, 1'b0);
        end
        1: begin
          chk("c1_ren", RAM_REN, 1'b1);
          chk("c1_raddr", {23'd0, RAM_RADDR}, 0);
          chk("c1_count", {22'd0, COUNT}, 1);
          chk("c1_empty", EMPTY, 1'b0);
        end
        2, 3: chk("c23_rd_valid", RD_VALID, 1'b0);
        4: begin
          chk("c4_rd_valid", RD_VALID, 1'b1);
          chk("c4_rd_data", RD_DATA, 32'hDEADBEEF);
        end
        default: begin
          chk("c5_empty", EMPTY, 1'b1);
          chk("c5_count", {22'd0, COUNT}, 0);
          chk("c5_rd_valid", RD_VALID, 1'b0);
        end
      endcase
    end
    // fill to 515 words with no consumer, then drain in order
    do_reset();
    n = 0;
    for (int c = 0; c < 600 && n < 515; c++) begin
      @(negedge CLK);
      WR_VALID = 1'b1;
      WR_DATA = n;
      #1;
      if (WR_READY) n++;
    end
    chk("fill_n", n, 515);
    @(negedge CLK);
    WR_VALID = 1'b1;
    WR_DATA = 32'h0BAD;
    #1;
    chk("full", FULL, 1'b1);
    chk("full_wr_ready", WR_READY, 1'b0);
    chk("full_count", {22'd0, COUNT}, 515);
    chk("full_afull", AFULL, 1'b1);
    chk("full_wen", RAM_WEN, 1'b0);
    @(negedge CLK);
    WR_VALID = 1'b0;
    #1;
    chk("full_hold_count", {22'd0, COUNT}, 515);
    chk("full_hold", FULL, 1'b1);
    for (int i = 0; i < 515; i++) begin
      @(negedge CLK);
      RD_READY = 1'b1;
      #1;
      chk("drain_valid", RD_VALID, 1'b1);
      chk("drain_data", RD_DATA, i);
      chk("drain_count", {22'd0, COUNT}, 515 - i);
      chk("drain_afull", AFULL, 515 - i >= 500);
      chk("drain_aempty", AEMPTY, 515 - i <= 4);
    end
    @(negedge CLK);
    #1;
    chk("drain_end_valid", RD_VALID, 1'b0);
    chk("drain_end_empty", EMPTY, 1'b1);
    chk("drain_end_count", {22'd0, COUNT}, 0);
    chk("drain_end_aempty", AEMPTY, 1'b1);
    // continuous streaming through two pointer wraps
    do_reset();
    traffic(1200, 100, 100, 4);
    traffic(20, 0, 100, -1);
    chk("stream_end_count", {22'd0, COUNT}, 0);
    // reset with 20 words held and two reads in flight
    do_reset();
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      SRST = c == 22;
      WR_VALID = c <= 22;
      WR_DATA = 100 + c;
      RD_READY = c == 20 || c == 21 || c == 23;
      #1;
      if (c == 20 || c == 21) begin
        chk("mid_count", {22'd0, COUNT}, 20);
        chk("mid_rd_data", RD_DATA, 80 + c);
        chk("mid_ren", RAM_REN, 1'b1);
      end
      if (c == 22) begin
        chk("srst_count", {22'd0, COUNT}, 20);
        chk("srst_wen", RAM_WEN, 1'b0);
        chk("srst_ren", RAM_REN, 1'b0);
        chk("srst_srst_n", RAM_RD_SRST_N, 1'b0);
      end
      if (c == 23) begin
        chk("post_rst_count", {22'd0, COUNT}, 0);
        chk("post_rst_valid", RD_VALID, 1'b0);
        chk("post_rst_empty", EMPTY, 1'b1);
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      WR_VALID = 1'b0;
      RD_READY = 1'b1;
      #1;
      chk("stale_valid", RD_VALID, 1'b0);
      chk("stale_count", {22'd0, COUNT}, 0);
    end
    q.delete();
    // random traffic, including runs that reach FULL
    traffic(3000, 60, 50, -1);
    traffic(2000, 90, 40, -1);
    traffic(700, 0, 100, -1);
    chk("rand_end_count", {22'd0, COUNT}, 0);
    chk("rand_end_valid", RD_VALID, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
